// File: rtl/c64_bus_arbiter_pkg.sv
// Shared definitions for the C64 bus arbiter: FSM state encodings, bus owner codes and
// the default phase/BA timing also used by the vicii and mos6510 benches.
package c64_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BA_WAIT = 2'd1,
    ST_VIC_OWN = 2'd2,
    ST_DMA_OWN = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_VIC = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } bus_owner_t;

  localparam int DEF_DOTS_PER_CYCLE = 8;
  localparam int DEF_BA_DELAY       = 3;

endpackage

// File: rtl/c64_bus_arbiter_phi_phase_gen.sv
// phi0 phase generator: divides dot_clk into DOTS_PER_CYCLE dots, low half VIC, high half phi2.
// tick marks the last dot of each phi0 cycle, where the arbiter is allowed to change owner.
module c64_bus_arbiter_phi_phase_gen
  import c64_bus_arbiter_pkg::*;
#(
  parameter  int DOTS_PER_CYCLE = DEF_DOTS_PER_CYCLE,
  localparam int PH_W           = $clog2(DOTS_PER_CYCLE)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [PH_W-1:0] o_ph,
  output logic            o_phi2,
  output logic            o_tick
);

  logic [PH_W-1:0] r_ph;
  logic            r_phi2;
  logic [PH_W-1:0] w_ph_next;

  assign o_tick    = (r_ph == PH_W'(DOTS_PER_CYCLE - 1));
  assign w_ph_next = o_tick ? '0 : r_ph + 1'b1;

  // phi2 is registered from the next phase so it always matches r_ph in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ph   <= '0;
      r_phi2 <= 1'b0;
    end else begin
      r_ph   <= w_ph_next;
      r_phi2 <= (w_ph_next >= PH_W'(DOTS_PER_CYCLE / 2));
    end
  end

  assign o_ph   = r_ph;
  assign o_phi2 = r_phi2;

endmodule

// File: rtl/c64_bus_arbiter.sv
// C64 system bus arbiter: VIC-II / 6510 / expansion DMA ownership with the BA->AEC delay rule
// and the shared bus mux. Optional stolen-cycle counter enabled by defining BUS_ARB_STATS_EN.
module c64_bus_arbiter
  import c64_bus_arbiter_pkg::*;
#(
  parameter int DOTS_PER_CYCLE = DEF_DOTS_PER_CYCLE,
  parameter int BA_DELAY       = DEF_BA_DELAY,
  parameter int ADDR_W         = 16
) (
  input  logic              i_dot_clk,
  input  logic              i_reset,
  input  logic              i_vic_req,
  input  logic [ADDR_W-1:0] i_vic_addr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_we,
  input  logic [7:0]        i_cpu_do,
  input  logic              i_dma_req,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic              i_dma_we,
  input  logic [7:0]        i_dma_do,
  output logic              o_phi2,
  output logic              o_ba,
  output logic              o_aec,
  output logic              o_rdy,
  output logic              o_dma_grant,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic              o_bus_we,
  output logic [7:0]        o_bus_di,
  output logic [15:0]       o_stolen_cnt
);

  localparam int PH_W  = $clog2(DOTS_PER_CYCLE);
  localparam int CNT_W = (BA_DELAY > 1) ? $clog2(BA_DELAY) : 1;

  logic [PH_W-1:0]  w_ph;
  logic             w_phi2;
  logic             w_tick;
  logic             w_unused_ph;
  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dma_grant;
  logic             w_ba;
  logic             w_aec;
  bus_owner_t       w_owner;

  c64_bus_arbiter_phi_phase_gen #(
    .DOTS_PER_CYCLE(DOTS_PER_CYCLE)
  ) u_phase (
    .i_clk   (i_dot_clk),
    .i_reset (i_reset),
    .o_ph    (w_ph),
    .o_phi2  (w_phi2),
    .o_tick  (w_tick)
  );

  assign w_unused_ph = ^w_ph;

  always_ff @(posedge i_dot_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dma_grant <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (i_vic_req) begin
            r_state <= ST_BA_WAIT;
            r_cnt   <= CNT_W'(BA_DELAY - 1);
          end else if (i_dma_req) begin
            r_state     <= ST_DMA_OWN;
            r_dma_grant <= 1'b1;
          end
        end
        // a DMA master keeps its grant through BA_WAIT so it can finish before the VIC stalls it
        ST_BA_WAIT: begin
          if (!i_vic_req) begin
            r_state     <= ST_IDLE;
            r_dma_grant <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state     <= ST_VIC_OWN;
            r_dma_grant <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_VIC_OWN: begin
          if (!i_vic_req) begin
            if (i_dma_req) begin
              r_state     <= ST_DMA_OWN;
              r_dma_grant <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DMA_OWN: begin
          if (i_vic_req) begin
            r_state <= ST_BA_WAIT;
            r_cnt   <= CNT_W'(BA_DELAY - 1);
          end else if (!i_dma_req) begin
            r_state     <= ST_IDLE;
            r_dma_grant <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_dma_grant <= 1'b0;
        end
      endcase
    end
  end

  assign w_ba  = (r_state == ST_BA_WAIT) || (r_state == ST_VIC_OWN);
  assign w_aec = w_phi2 && (r_state != ST_VIC_OWN);

  assign o_phi2      = w_phi2;
  assign o_ba        = w_ba;
  assign o_aec       = w_aec;
  assign o_dma_grant = r_dma_grant;
  assign o_rdy       = ~w_ba & ~r_dma_grant;

  always_comb begin
    w_owner = OWN_VIC;
    if (w_aec) w_owner = r_dma_grant ? OWN_DMA : OWN_CPU;
  end

  // the VIC never writes, so bus_we stays low whenever it owns the bus
  always_comb begin
    o_bus_address = i_vic_addr;
    o_bus_we      = 1'b0;
    case (w_owner)
      OWN_CPU: begin
        o_bus_address = i_cpu_addr;
        o_bus_we      = i_cpu_we;
      end
      OWN_DMA: begin
        o_bus_address = i_dma_addr;
        o_bus_we      = i_dma_we;
      end
      default: ;
    endcase
  end

  assign o_bus_di = r_dma_grant ? i_dma_do : i_cpu_do;

`ifdef BUS_ARB_STATS_EN
  logic [15:0] r_stolen_cnt;

  always_ff @(posedge i_dot_clk) begin
    if (i_reset) begin
      r_stolen_cnt <= 16'h0000;
    end else if (w_tick && (r_state == ST_VIC_OWN) && (r_stolen_cnt != 16'hFFFF)) begin
      r_stolen_cnt <= r_stolen_cnt + 16'h0001;
    end
  end

  assign o_stolen_cnt = r_stolen_cnt;
`else
  assign o_stolen_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Scoreboard bench for c64_bus_arbiter: directed phi0 cycles push expected bus observations,
// a separate monitor compares them against the DUT half a dot later.
module tb_c64_bus_arbiter;

  localparam int O_VIC  = 0;
  localparam int O_CPU  = 1;
  localparam int O_DMA  = 2;
  localparam int S_IDLE = 0;
  localparam int S_BAW  = 1;
  localparam int S_VIC  = 2;
  localparam int S_DMA  = 3;
  localparam int S_BAWD = 4;

  logic        clk;
  logic        reset;
  logic        vic_req, cpu_we, dma_req, dma_we;
  logic [15:0] vic_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_do, dma_do;

  logic        phi2, ba, aec, rdy, dma_grant, bus_we;
  logic [15:0] bus_address, stolen_cnt;
  logic [7:0]  bus_di;

  typedef struct packed {
    logic        phi2;
    logic        ba;
    logic        aec;
    logic        rdy;
    logic        grant;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  di;
    logic [15:0] stolen;
  } obs_t;

  obs_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stolen = 16'd0;

  c64_bus_arbiter dut (
    .i_dot_clk     (clk),
    .i_reset       (reset),
    .i_vic_req     (vic_req),
    .i_vic_addr    (vic_addr),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_we      (cpu_we),
    .i_cpu_do      (cpu_do),
    .i_dma_req     (dma_req),
    .i_dma_addr    (dma_addr),
    .i_dma_we      (dma_we),
    .i_dma_do      (dma_do),
    .o_phi2        (phi2),
    .o_ba          (ba),
    .o_aec         (aec),
    .o_rdy         (rdy),
    .o_dma_grant   (dma_grant),
    .o_bus_address (bus_address),
    .o_bus_we      (bus_we),
    .o_bus_di      (bus_di),
    .o_stolen_cnt  (stolen_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // expected observation for dot d of a phi0 cycle whose high half belongs to hi
  task automatic dot_exp(input string nm, input int d, input logic e_ba, input logic e_grant,
                         input int hi);
    obs_t e;
    int   own;
    e.phi2  = (d >= 4);
    e.aec   = e.phi2 && (hi != O_VIC);
    e.ba    = e_ba;
    e.grant = e_grant;
    e.rdy   = !e_ba && !e_grant;
    own     = e.aec ? hi : O_VIC;
    case (own)
      O_CPU: begin
        e.addr = cpu_addr;
        e.we   = cpu_we;
      end
      O_DMA: begin
        e.addr = dma_addr;
        e.we   = dma_we;
      end
      default: begin
        e.addr = vic_addr;
        e.we   = 1'b0;
      end
    endcase
    e.di     = e_grant ? dma_do : cpu_do;
    e.stolen = exp_stolen;
    exp_q.push_back(e);
    name_q.push_back($sformatf("%s.d%0d", nm, d));
    @(negedge clk);
  endtask

  task automatic cyc(input string nm, input logic vr, input logic dr, input int st);
    logic e_ba, e_grant;
    int   hi;
    vic_req = vr;
    dma_req = dr;
    case (st)
      S_IDLE:  begin e_ba = 1'b0; e_grant = 1'b0; hi = O_CPU; end
      S_BAW:   begin e_ba = 1'b1; e_grant = 1'b0; hi = O_CPU; end
      S_VIC:   begin e_ba = 1'b1; e_grant = 1'b0; hi = O_VIC; end
      S_DMA:   begin e_ba = 1'b0; e_grant = 1'b1; hi = O_DMA; end
      default: begin e_ba = 1'b1; e_grant = 1'b1; hi = O_DMA; end
    endcase
    for (int d = 0; d < 8; d++) dot_exp(nm, d, e_ba, e_grant, hi);
`ifdef BUS_ARB_STATS_EN
    if (st == S_VIC) exp_stolen = exp_stolen + 16'd1;
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        obs_t  e;
        obs_t  a;
        string n;
        e        = exp_q.pop_front();
        n        = name_q.pop_front();
        a.phi2   = phi2;
        a.ba     = ba;
        a.aec    = aec;
        a.rdy    = rdy;
        a.grant  = dma_grant;
        a.we     = bus_we;
        a.addr   = bus_address;
        a.di     = bus_di;
        a.stolen = stolen_cnt;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: actual phi2=%b ba=%b aec=%b rdy=%b grant=%b we=%b addr=%h di=%h stolen=%0d required phi2=%b ba=%b aec=%b rdy=%b grant=%b we=%b addr=%h di=%h stolen=%0d",
                   n, a.phi2, a.ba, a.aec, a.rdy, a.grant, a.we, a.addr, a.di, a.stolen,
                   e.phi2, e.ba, e.aec, e.rdy, e.grant, e.we, e.addr, e.di, e.stolen);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    vic_req  = 1'b0;
    dma_req  = 1'b0;
    cpu_we   = 1'b0;
    dma_we   = 1'b0;
    vic_addr = 16'h0400;
    cpu_addr = 16'hE000;
    cpu_do   = 8'h3C;
    dma_addr = 16'h8000;
    dma_do   = 8'hA5;
    repeat (3) @(negedge clk);
    dot_exp("reset", 0, 1'b0, 1'b0, O_CPU);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) cyc("idle", 1'b0, 1'b0, S_IDLE);

    cyc("vreq", 1'b1, 1'b0, S_IDLE);
    cyc("baw1", 1'b1, 1'b0, S_BAW);
    cpu_we   = 1'b1;
    cpu_addr = 16'hD020;
    cpu_do   = 8'h05;
    cyc("baw2_wr", 1'b1, 1'b0, S_BAW);
    cyc("baw3_wr", 1'b1, 1'b0, S_BAW);
    cyc("vic_wr_blocked", 1'b1, 1'b0, S_VIC);
    cyc("vic_release", 1'b0, 1'b0, S_VIC);
    cpu_we   = 1'b0;
    cpu_addr = 16'hE000;
    cpu_do   = 8'h3C;
    cyc("idle_after_vic", 1'b0, 1'b0, S_IDLE);

    cyc("dreq", 1'b0, 1'b1, S_IDLE);
    dma_we = 1'b1;
    cyc("dma_wr", 1'b0, 1'b1, S_DMA);
    dma_we = 1'b0;
    cyc("dma_rd", 1'b0, 1'b1, S_DMA);

    cyc("dma_vreq", 1'b1, 1'b1, S_DMA);
    cyc("bawd1", 1'b1, 1'b1, S_BAWD);
    cyc("bawd2", 1'b1, 1'b1, S_BAWD);
    cyc("bawd3", 1'b1, 1'b1, S_BAWD);
    cyc("vic_over_dma", 1'b1, 1'b1, S_VIC);
    cyc("vic_drop_dma_held", 1'b0, 1'b1, S_VIC);
    cyc("dma_back", 1'b0, 1'b1, S_DMA);
    cyc("dma_drop", 1'b0, 1'b0, S_DMA);
    cyc("idle_after_dma", 1'b0, 1'b0, S_IDLE);

    cyc("both_req", 1'b1, 1'b1, S_IDLE);
    cyc("pulse_baw", 1'b0, 1'b0, S_BAW);
    cyc("abort_idle", 1'b0, 1'b0, S_IDLE);

    cyc("r_vreq", 1'b1, 1'b0, S_IDLE);
    for (int i = 0; i < 3; i++) cyc("r_baw", 1'b1, 1'b0, S_BAW);
    cyc("r_vic", 1'b1, 1'b0, S_VIC);
    for (int d = 0; d < 3; d++) dot_exp("r_vic_mid", d, 1'b1, 1'b0, O_VIC);
    reset = 1'b1;
    dot_exp("r_vic_mid", 3, 1'b1, 1'b0, O_VIC);
    exp_stolen = 16'd0;
    vic_req    = 1'b0;
    dot_exp("reset_mid", 0, 1'b0, 1'b0, O_CPU);
    reset = 1'b0;
    cyc("idle_after_reset", 1'b0, 1'b0, S_IDLE);

    cyc("s_vreq", 1'b1, 1'b0, S_IDLE);
    for (int i = 0; i < 3; i++) cyc("s_baw", 1'b1, 1'b0, S_BAW);
    for (int i = 0; i < 39; i++) cyc("s_vic", 1'b1, 1'b0, S_VIC);
    cyc("s_vic_last", 1'b0, 1'b0, S_VIC);
    cyc("s_stolen40", 1'b0, 1'b0, S_IDLE);

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
